// File: rtl/mem_fetch_responder_if.sv
// Bus between the memory fetch responder and its surroundings: the address
// controller handshake, the synchronous RAM read port and the downstream
// valid/ready consumer port.
// Optional macro FETCH_COUNT_EN adds the fetch_count signal.
interface mem_fetch_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] address_in;
    logic              output_enable;
    logic              end_of_memory;
    logic              fetch_data_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              done;
`ifdef FETCH_COUNT_EN
    logic [ADDR_W-1:0] fetch_count;
`endif

    // Responder view: the mem_fetch_responder block itself.
    modport slave (
        input  address_in, output_enable, end_of_memory, mem_rdata, data_ready,
        output fetch_data_ready, mem_addr, mem_rd_en, data_out, data_valid, done
`ifdef FETCH_COUNT_EN
        , output fetch_count
`endif
    );

    // Environment view: controller, RAM and consumer.
    modport master (
        output address_in, output_enable, end_of_memory, mem_rdata, data_ready,
        input  fetch_data_ready, mem_addr, mem_rd_en, data_out, data_valid, done
`ifdef FETCH_COUNT_EN
        , input fetch_count
`endif
    );
endinterface

// File: rtl/mem_fetch_responder.sv
// Responder side of the address / fetch_data_ready handshake. Reads the
// current controller address from a fixed-latency synchronous RAM, offers
// the word to a consumer via valid/ready, then pulses fetch_data_ready so
// the controller advances. Stops for good once end_of_memory is seen.
// Optional macro FETCH_COUNT_EN adds a saturating count of accepted words.
module mem_fetch_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int PULSE_W    = 2,
    parameter int SETTLE_CYC = 2
) (
    input logic                  clk,
    input logic                  rst,
    mem_fetch_responder_if.slave bus
);
    typedef enum logic [2:0] {
        PRIME, WAIT_OE, ISSUE, WAIT_RD, HOLD, PULSE, SETTLE, DONE
    } state_t;

    // One shared counter covers pulse width, settle time and read latency.
    localparam int CNT_MAX0 = (PULSE_W > SETTLE_CYC) ? PULSE_W : SETTLE_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > RD_LATENCY) ? CNT_MAX0 : RD_LATENCY;
    localparam int CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_END      = CNT_W'(RD_LATENCY);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Fetch sequencer: every output is a register written only here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= PRIME;
            cnt                  <= '0;
            bus.fetch_data_ready <= 1'b0;
            bus.mem_rd_en        <= 1'b0;
            bus.mem_addr         <= '0;
            bus.data_out         <= '0;
            bus.data_valid       <= 1'b0;
            bus.done             <= 1'b0;
`ifdef FETCH_COUNT_EN
            bus.fetch_count      <= '0;
`endif
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the case
            // overrides it, so mem_rd_en is high only in the cycle after ISSUE.
            bus.mem_rd_en <= 1'b0;
            case (state)
                // Priming pulse: controller enables output, does not advance.
                PRIME: begin
                    if (cnt == PULSE_END) begin
                        bus.fetch_data_ready <= 1'b0;
                        cnt                  <= '0;
                        state                <= SETTLE;
                    end else begin
                        bus.fetch_data_ready <= 1'b1;
                        cnt                  <= cnt + ONE;
                    end
                end
                // Give the controller time to update address / end flag.
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (bus.end_of_memory) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else if (bus.output_enable) begin
                            state <= ISSUE;
                        end else begin
                            state <= WAIT_OE;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                WAIT_OE: begin
                    if (bus.end_of_memory) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (bus.output_enable) begin
                        state <= ISSUE;
                    end
                end
                // address_in is sampled here and nowhere else.
                ISSUE: begin
                    bus.mem_addr  <= ADDR_W'(bus.address_in);
                    bus.mem_rd_en <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (cnt == RD_END) begin
                        bus.data_out   <= DATA_W'(bus.mem_rdata);
                        bus.data_valid <= 1'b1;
                        cnt            <= '0;
                        state          <= HOLD;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                // Pulse starts on the handshake edge itself.
                HOLD: begin
                    if (bus.data_ready) begin
                        bus.data_valid       <= 1'b0;
                        bus.fetch_data_ready <= 1'b1;
                        cnt                  <= ONE;
                        state                <= PULSE;
`ifdef FETCH_COUNT_EN
                        if (bus.fetch_count != '1)
                            bus.fetch_count <= bus.fetch_count + ADDR_W'(1);
`endif
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_END) begin
                        bus.fetch_data_ready <= 1'b0;
                        cnt                  <= '0;
                        state                <= SETTLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: begin
                    bus.fetch_data_ready <= 1'b0;
                    bus.data_valid       <= 1'b0;
                    bus.done             <= 1'b1;
                end
                default: state <= PRIME;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_fetch_responder.sv
// Directed bench for mem_fetch_responder: a latency-1 instance driven by a
// controller model (threshold 35) and a latency-3 instance for latency and
// backpressure. RAM word = addr ^ 32'hA5A5A5A5.
// Define FETCH_COUNT_EN to also check fetch_count.
module tb_mem_fetch_responder;
    localparam logic [31:0] PAT    = 32'hA5A5A5A5;
    localparam logic [31:0] THRESH = 32'd35;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_fetch_responder #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .PULSE_W(2), .SETTLE_CYC(2))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_fetch_responder #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .PULSE_W(2), .SETTLE_CYC(2))
        dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    // RAM models: data appears RD_LATENCY edges after the read strobe edge.
    logic [31:0] r1;
    logic [31:0] r3a, r3b, r3c;
    always @(posedge clk) begin
        r1  <= b1.mem_rd_en ? (b1.mem_addr ^ PAT) : 32'h0;
        r3a <= b3.mem_rd_en ? (b3.mem_addr ^ PAT) : 32'h0;
        r3b <= r3a;
        r3c <= r3b;
    end
    assign b1.mem_rdata = r1;
    assign b3.mem_rdata = r3c;

    // Controller model: first rising edge primes, later edges advance.
    logic [31:0] ctl_addr, ctl_start;
    logic        ctl_oe, ctl_eom, ctl_primed, fdr_q, oe_block, early_eom;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_addr   <= ctl_start;
            ctl_oe     <= 1'b0;
            ctl_eom    <= 1'b0;
            ctl_primed <= 1'b0;
            fdr_q      <= 1'b0;
        end else begin
            fdr_q <= b1.fetch_data_ready;
            if (b1.fetch_data_ready && !fdr_q) begin
                if (!ctl_primed) begin
                    ctl_primed <= 1'b1;
                    ctl_oe     <= 1'b1;
                end else if (ctl_addr == THRESH) begin
                    ctl_eom <= 1'b1;
                end else begin
                    ctl_addr <= ctl_addr + 32'd1;
                end
            end
            if (early_eom && b1.mem_rd_en && b1.mem_addr == THRESH)
                ctl_eom <= 1'b1;
        end
    end
    assign b1.address_in    = ctl_addr;
    assign b1.output_enable = ctl_oe & ~oe_block;
    assign b1.end_of_memory = ctl_eom;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs dut1 until done (bounded), checking every accepted word in order.
    task automatic run_until_done(input string tag, input logic [31:0] first, output int n, output int rises);
        logic        prev;
        logic [31:0] exp;
        n     = 0;
        rises = 0;
        prev  = b1.fetch_data_ready;
        for (int c = 0; c < 2000; c++) begin
            if (b1.done) break;
            @(negedge clk);
            if (b1.data_valid && b1.data_ready) begin
                exp = (first + 32'(n)) ^ PAT;
                check({tag, "_word"}, 64'(b1.data_out), 64'(exp));
                n++;
            end
            if (b1.fetch_data_ready && !prev) rises++;
            prev = b1.fetch_data_ready;
        end
        check({tag, "_done"}, 64'(b1.done), 64'd1);
    endtask

    // After DONE: no reads, no pulses, done stays high.
    task automatic idle_check(input string tag);
        int rd, hi;
        rd = 0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b1.mem_rd_en) rd++;
            if (b1.fetch_data_ready) hi++;
        end
        check({tag, "_rd_after_done"}, 64'(rd), 64'd0);
        check({tag, "_fdr_after_done"}, 64'(hi), 64'd0);
        check({tag, "_done_sticky"}, 64'(b1.done), 64'd1);
    endtask

    initial begin
        int          rises, high, rden, c_rd, c_dv, n, viol, dvs;
        logic        prev, hit;
        logic [31:0] snap;

        // NOTE: stimulus uses blocking assignments; outputs are sampled on negedge.
        ctl_start        = 32'd0;
        oe_block         = 1'b1;
        early_eom        = 1'b0;
        b1.data_ready    = 1'b0;
        b3.address_in    = 32'd7;
        b3.output_enable = 1'b1;
        b3.end_of_memory = 1'b0;
        b3.data_ready    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_fdr", 64'(b1.fetch_data_ready), 64'd0);
        check("rst_rd_en", 64'(b1.mem_rd_en), 64'd0);
        check("rst_mem_addr", 64'(b1.mem_addr), 64'd0);
        check("rst_data_out", 64'(b1.data_out), 64'd0);
        check("rst_valid", 64'(b1.data_valid), 64'd0);
        check("rst_done", 64'(b1.done), 64'd0);
        rst = 1'b1;

        // Priming with output_enable forced low; dut3 fetches address 7.
        rises = 0; high = 0; rden = 0; prev = 1'b0; c_rd = -1; c_dv = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b1.fetch_data_ready) high++;
            if (b1.fetch_data_ready && !prev) rises++;
            prev = b1.fetch_data_ready;
            if (b1.mem_rd_en) rden++;
            if (b3.mem_rd_en && c_rd < 0) c_rd = i;
            if (b3.data_valid && c_dv < 0) c_dv = i;
        end
        check("prime_rises", 64'(rises), 64'd1);
        check("prime_width", 64'(high), 64'd2);
        check("wait_oe_no_rd", 64'(rden), 64'd0);
        check("lat3_issue_seen", 64'(c_rd >= 0), 64'd1);
        check("lat3_valid_delay", 64'(c_dv - c_rd), 64'd4);
        check("lat3_data", 64'(b3.data_out), 64'hA5A5A5A2);

        // Backpressure on dut3 for 20 cycles.
        snap = b3.data_out;
        viol = 0;
        rden = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b3.data_out !== snap || b3.data_valid !== 1'b1 || b3.fetch_data_ready !== 1'b0) viol++;
            if (b1.mem_rd_en || b1.fetch_data_ready) rden++;
        end
        check("hold_stable", 64'(viol), 64'd0);
        check("wait_oe_idle", 64'(rden), 64'd0);
        b3.data_ready = 1'b1;
        @(negedge clk);
        check("hs_pulse", 64'(b3.fetch_data_ready), 64'd1);
        check("hs_valid_drop", 64'(b3.data_valid), 64'd0);
        b3.data_ready    = 1'b0;
        b3.end_of_memory = 1'b1;
        repeat (8) @(negedge clk);
        check("lat3_done", 64'(b3.done), 64'd1);

        // Full sweep 0..35.
        oe_block      = 1'b0;
        b1.data_ready = 1'b1;
        run_until_done("sweep", 32'd0, n, rises);
        check("sweep_words", 64'(n), 64'd36);
        check("sweep_pulses", 64'(rises), 64'd36);
`ifdef FETCH_COUNT_EN
        check("sweep_fetch_count", 64'(b1.fetch_count), 64'd36);
`endif
        idle_check("sweep");

        // end_of_memory raised during WAIT_RD of address 35.
        ctl_start = 32'd30;
        early_eom = 1'b1;
        do_reset();
        run_until_done("late_eom", 32'd30, n, rises);
        check("late_eom_words", 64'(n), 64'd6);
        check("late_eom_pulses", 64'(rises), 64'd7);
        check("late_eom_last_addr", 64'(b1.mem_addr), 64'd35);
`ifdef FETCH_COUNT_EN
        check("late_eom_fetch_count", 64'(b1.fetch_count), 64'd6);
`endif
        idle_check("late_eom");

        // Reset during the pulse that follows word 12.
        ctl_start = 32'd0;
        early_eom = 1'b0;
        do_reset();
        n   = 0;
        hit = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (b1.data_valid && b1.data_ready) begin
                check("pre_rst_word", 64'(b1.data_out), 64'(32'(n) ^ PAT));
                n++;
            end
            if (n == 13 && b1.fetch_data_ready) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_pulse_reached", 64'(hit), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_fdr", 64'(b1.fetch_data_ready), 64'd0);
        check("mid_rst_valid", 64'(b1.data_valid), 64'd0);
        check("mid_rst_mem_addr", 64'(b1.mem_addr), 64'd0);
        check("mid_rst_data_out", 64'(b1.data_out), 64'd0);
`ifdef FETCH_COUNT_EN
        check("mid_rst_fetch_count", 64'(b1.fetch_count), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        rises = 0; high = 0; dvs = 0; prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b1.fetch_data_ready) high++;
            if (b1.fetch_data_ready && !prev) rises++;
            prev = b1.fetch_data_ready;
            if (b1.data_valid) dvs++;
        end
        check("reprime_rises", 64'(rises), 64'd1);
        check("reprime_width", 64'(high), 64'd2);
        check("no_stale_valid", 64'(dvs), 64'd0);
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (b1.data_valid && b1.data_ready) begin
                hit = 1'b1;
                check("restart_word", 64'(b1.data_out), 64'(PAT));
                break;
            end
        end
        check("restart_delivered", 64'(hit), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_fetch_responder.md
Name: mem_fetch_responder

Overview:
- Responder side of the memory controller's address/fetch_data_ready handshake.
- Takes the current address and output_enable from the address controller, reads a synchronous RAM with fixed read latency, and presents each word to a downstream consumer via valid/ready.
- Pulses fetch_data_ready once the word is accepted; the controller advances its address on that pulse.
- Stops after end_of_memory is raised.

Parameters:
- ADDR_W, 32, address width (matches controller address bus).
- DATA_W, 32, memory data width.
- RD_LATENCY, 1, RAM read latency in clk cycles; legal range 1..4.
- PULSE_W, 2, number of clk cycles fetch_data_ready is held high per pulse; minimum 1.
- SETTLE_CYC, 2, clk cycles waited after a pulse before sampling address_in/end_of_memory; minimum 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- address_in  input  ADDR_W  current address from controller.
- output_enable  input  1  controller has been primed; fetches permitted.
- end_of_memory  input  1  controller reached its threshold.
- fetch_data_ready  output  1  handshake pulse to controller (rising edge = advance).
- mem_addr  output  ADDR_W  RAM read address.
- mem_rd_en  output  1  RAM read strobe, one cycle per fetch.
- mem_rdata  input  DATA_W  RAM read data, valid RD_LATENCY cycles after mem_rd_en.
- data_out  output  DATA_W  fetched word to consumer.
- data_valid  output  1  data_out valid.
- data_ready  input  1  consumer accepts when data_valid && data_ready.
- done  output  1  sticky, memory sweep complete.

Behaviour:
- Reset (rst low, async): state=PRIME, fetch_data_ready=0, mem_rd_en=0, mem_addr=0, data_out=0, data_valid=0, done=0, internal counters=0.
- FSM states: PRIME, WAIT_OE, ISSUE, WAIT_RD, HOLD, PULSE, SETTLE, DONE.
- PRIME:
  - Drive fetch_data_ready high for PULSE_W cycles (priming pulse; the controller sets output_enable and its first-edge flag and does not advance).
  - Then go to SETTLE.
- SETTLE:
  - fetch_data_ready=0 for SETTLE_CYC cycles.
  - On the last cycle, if end_of_memory=1, go to DONE.
  - Else if output_enable=1, go to ISSUE.
  - Else go to WAIT_OE.
- WAIT_OE: remain until output_enable=1, then go to ISSUE. end_of_memory=1 here also goes to DONE; end_of_memory has priority.
- ISSUE: mem_addr<=address_in, mem_rd_en=1 for exactly one cycle, go to WAIT_RD.
- WAIT_RD:
  - Count RD_LATENCY cycles from the mem_rd_en cycle.
  - Capture mem_rdata into data_out, set data_valid=1, go to HOLD.
  - Total ISSUE-to-data_valid latency is RD_LATENCY+1 cycles.
- HOLD:
  - data_out stable while data_valid=1.
  - On data_valid && data_ready: data_valid<=0, go to PULSE.
  - Backpressure may last indefinitely.
- PULSE: fetch_data_ready=1 for PULSE_W cycles, then go to SETTLE.
- DONE:
  - done=1, all strobes 0; terminal until reset.
  - A late end_of_memory does not abort a word already in WAIT_RD/HOLD; the word is still delivered and pulsed.
- Exactly one fetch_data_ready rising edge per delivered word, plus the single priming edge after reset.
- fetch_data_ready is never high in consecutive pulses without ≥SETTLE_CYC low cycles between them.
- mem_addr holds its last value when idle; address_in is sampled only in ISSUE.
- Reset mid-operation:
  - Immediate return to PRIME; in-flight RAM data is discarded.
  - data_valid drops asynchronously.
  - A pulse in progress is truncated to 0.
- address_in wrap: no arithmetic is performed on it; any value is passed through.

Optional Feature:
- FETCH_COUNT_EN: when defined, adds output fetch_count [ADDR_W-1:0].
  - Reset 0; increments by 1 on each consumer handshake (data_valid && data_ready).
  - Saturates at all-ones; holds its value in DONE.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release with output_enable forced 0 -> exactly one PULSE_W-wide fetch_data_ready pulse, then WAIT_OE; mem_rd_en stays 0.
- Connect the controller model (threshold 35), RAM preloaded with word=addr^32'hA5A5A5A5, data_ready=1 -> 36 words delivered for addresses 0..35 in order, data_out correct each time; done=1 after the 36th pulse; fetch_count=36 with FETCH_COUNT_EN.
- RD_LATENCY=3, single fetch at address 7 -> data_valid rises exactly 4 cycles after the ISSUE cycle; data_out=mem[7].
- data_ready held 0 for 20 cycles during HOLD -> data_out/data_valid stable, fetch_data_ready stays 0; pulse occurs within 1 cycle of the handshake.
- Assert end_of_memory during WAIT_RD of address 35 -> word 35 still delivered and pulsed, then DONE with no further mem_rd_en.
- Drop rst during PULSE mid-sweep (address 12) -> outputs reset immediately; after release, priming pulse again; no stale data_valid.
